axi_wr_rr_arbiter: RTL and testbench
====================================

// Module: axi_wr_rr_arbiter
// PURPOSE
// - Two-requester round-robin arbiter for the AXI4 write path (AW/W/B) onto one slave port.
// - Sits between two write masters (e.g. DMA and CPU bridge) and the 16-bit-address / 32-bit-data AXI slave.
// - Grants one whole burst at a time (AW -> all W beats -> B) and regenerates WLAST from AWLEN.
// - Flags requester WLAST errors.
// PARAMETERS
// ID_W    8   AWID/BID width
// ADDR_W  16  AWADDR width
// DATA_W  32  WDATA width; WSTRB width = DATA_W/8
// AW_W = ID_W+ADDR_W+8+3+2 (derived, not overridable); AW payload packing is {awid,awaddr,awlen[7:0],awsize[2:0],awburst[1:0]}
// W_W  = DATA_W+DATA_W/8+1 (derived); W payload packing is {wdata,wstrb,wlast}
// PORTS
// clk         in   1        clock, all logic on posedge
// rst         in   1        asynchronous, active-low reset
// m_aw        in   2*AW_W   AW payloads; requester i in [i*AW_W +: AW_W]
// m_awvalid   in   2        per-requester AWVALID
// m_awready   out  2        per-requester AWREADY
// m_w         in   2*W_W    W payloads; requester i in [i*W_W +: W_W]
// m_wvalid    in   2        per-requester WVALID
// m_wready    out  2        per-requester WREADY
// m_bid       out  2*ID_W   BID returned to requester i
// m_bresp     out  2*2      BRESP returned to requester i
// m_bvalid    out  2        per-requester BVALID
// m_bready    in   2        per-requester BREADY
// s_aw        out  AW_W     AW payload to slave
// s_awvalid   out  1        AWVALID to slave
// s_awready   in   1        AWREADY from slave
// s_w         out  W_W      W payload to slave; wlast bit regenerated internally
// s_wvalid    out  1        WVALID to slave
// s_wready    in   1        WREADY from slave
// s_bid       in   ID_W     BID from slave
// s_bresp     in   2        BRESP from slave
// s_bvalid    in   1        BVALID from slave
// s_bready    out  1        BREADY to slave
// grant       out  2        one-hot owner of the current burst; 0 in IDLE
// wlast_err   out  1        1-cycle pulse on a requester WLAST mismatch
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, grant=0, last=1 (requester 0 wins first), beat_cnt=0.
//   All ready/valid outputs and wlast_err are 0. A reset mid-burst abandons the burst with no cleanup.
// - FSM IDLE -> AW -> W -> BR -> IDLE. State, grant and beat_cnt are registered.
//   All channel muxing is combinational from grant; no payload register.
// - IDLE: if any m_awvalid is set, register grant next cycle and go to AW.
//   - Only one valid: that requester wins.
//   - Both valid: winner = ~last.
//   - No ready is asserted in IDLE.
// - AW: s_aw = m_aw[g]; s_awvalid = m_awvalid[g]; m_awready[g] = s_awready.
//   - On s_awvalid&s_awready: beat_cnt <= awlen, go to W.
// - W: s_w data/strb = m_w[g]; s_wlast = (beat_cnt==0); s_wvalid = m_wvalid[g]; m_wready[g] = s_wready.
//   - Each W handshake: beat_cnt-1. The handshake with beat_cnt==0 goes to BR.
//   - Requester wlast != (beat_cnt==0) on a handshake: wlast_err=1 next cycle. The beat is still forwarded.
// - BR: m_bvalid[g] = s_bvalid; m_bid/m_bresp[g] = s_bid/s_bresp; s_bready = m_bready[g].
//   - On handshake: last <= g, grant <= 0, go to IDLE.
// - Non-granted requester: awready=wready=bvalid=0 always, and its bid/bresp outputs are 0.
//   - W data presented before its AW is granted is held off (wready=0) until the W state.
// - Outside AW: s_awvalid=0. Outside W: s_wvalid=0. Outside BR: s_bready=0.
//   - A slave BVALID arriving before BR is ignored until BR.
// - Latency: 1 cycle from m_awvalid (in IDLE) to s_awvalid. 1 dead IDLE cycle between bursts.
//   - Max throughput is 1 beat/cycle inside a burst.
// - awlen=0 (single beat): W state lasts until one handshake, and s_wlast=1 on it. awlen=255 means 256 beats, and beat_cnt is 8 bits.
// - Only one outstanding burst. Fairness: strict alternation while both requesters keep AWVALID high.
// TESTING
// - Single req0 burst, awlen=3, slave always ready -> s_awvalid 1 cycle after m_awvalid; 4 W beats, s_wlast on the 4th; m_bvalid[0] mirrors BRESP=OKAY; grant 01 -> 00.
// - Both requesters assert awvalid after reset -> order 0,1,0,1 over 4 bursts (awlen=0); grant never 11.
// - Slave drops s_wready for 3 cycles mid-burst (awlen=7) -> 8 beats forwarded in order; no beats lost or duplicated.
// - Req1 burst awlen=2 with wlast asserted on beat 2 -> s_wlast only on beat 3; wlast_err pulses once.
// - Reset (rst=0) during W of an awlen=15 burst -> all valid/ready outputs 0 asynchronously; next burst after release granted to req0.
// - awlen=255 -> exactly 256 W handshakes before BR; early s_bvalid during W not acknowledged (s_bready=0).

Source files
------------

// File: rtl/axi_wr_rr_arbiter.sv
// Two-requester round-robin arbiter for the AXI4 write path. It grants one whole burst
// (AW, then all W beats, then B) at a time and regenerates WLAST from AWLEN.
module axi_wr_rr_arbiter #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW_W  = ID_W + ADDR_W + 8 + 3 + 2,
  localparam int unsigned W_W   = DATA_W + DATA_W / 8 + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*AW_W-1:0]   m_aw,
  input  logic [1:0]          m_awvalid,
  output logic [1:0]          m_awready,
  input  logic [2*W_W-1:0]    m_w,
  input  logic [1:0]          m_wvalid,
  output logic [1:0]          m_wready,
  output logic [2*ID_W-1:0]   m_bid,
  output logic [3:0]          m_bresp,
  output logic [1:0]          m_bvalid,
  input  logic [1:0]          m_bready,
  output logic [AW_W-1:0]     s_aw,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [W_W-1:0]      s_w,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [ID_W-1:0]     s_bid,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [1:0]          grant,
  output logic                wlast_err
);

  typedef enum logic [1:0] {StIdle, StAw, StW, StBr} state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic        last_q;
  logic [7:0]  beat_cnt_q;
  logic        wlast_err_q;

  logic            gi;
  logic [AW_W-1:0] aw_g;
  logic [W_W-1:0]  w_g;
  logic            wlast_gen;

  assign gi        = grant_q[1];
  assign aw_g      = gi ? m_aw[AW_W +: AW_W] : m_aw[0 +: AW_W];
  assign w_g       = gi ? m_w[W_W +: W_W] : m_w[0 +: W_W];
  assign wlast_gen = (beat_cnt_q == 8'd0);
  assign grant     = grant_q;
  assign wlast_err = wlast_err_q;

  always_comb begin
    s_aw      = aw_g;
    s_awvalid = 1'b0;
    m_awready = 2'b00;
    s_w       = {w_g[W_W-1:1], wlast_gen};
    s_wvalid  = 1'b0;
    m_wready  = 2'b00;
    s_bready  = 1'b0;
    m_bvalid  = 2'b00;
    m_bid     = '0;
    m_bresp   = 4'b0000;
    unique case (state_q)
      StAw: begin
        s_awvalid     = m_awvalid[gi];
        m_awready[gi] = s_awready;
      end
      StW: begin
        s_wvalid     = m_wvalid[gi];
        m_wready[gi] = s_wready;
      end
      StBr: begin
        s_bready     = m_bready[gi];
        m_bvalid[gi] = s_bvalid;
        m_bid        = gi ? {s_bid, {ID_W{1'b0}}} : {{ID_W{1'b0}}, s_bid};
        m_bresp      = gi ? {s_bresp, 2'b00} : {2'b00, s_bresp};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      beat_cnt_q  <= 8'd0;
      wlast_err_q <= 1'b0;
    end else begin
      wlast_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|m_awvalid) begin
            // On contention the requester that did not own the last burst wins.
            grant_q <= (m_awvalid == 2'b11) ? (last_q ? 2'b01 : 2'b10) : m_awvalid;
            state_q <= StAw;
          end
        end
        StAw: begin
          if (s_awvalid && s_awready) begin
            beat_cnt_q <= aw_g[12:5];
            state_q    <= StW;
          end
        end
        StW: begin
          if (s_wvalid && s_wready) begin
            wlast_err_q <= (w_g[0] != wlast_gen);
            beat_cnt_q  <= beat_cnt_q - 8'd1;
            if (wlast_gen) state_q <= StBr;
          end
        end
        StBr: begin
          if (s_bvalid && s_bready) begin
            last_q  <= gi;
            grant_q <= 2'b00;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Directed bench for axi_wr_rr_arbiter: burst sequencing, round-robin order, W stalls,
// WLAST regeneration and errors, async reset mid-burst and 256-beat bursts.
module tb_axi_wr_rr_arbiter;
  localparam int ID_W   = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int AW_W   = ID_W + ADDR_W + 13;
  localparam int W_W    = DATA_W + DATA_W / 8 + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2*AW_W-1:0] m_aw = '0;
  logic [1:0]        m_awvalid = '0;
  logic [1:0]        m_awready;
  logic [2*W_W-1:0]  m_w = '0;
  logic [1:0]        m_wvalid = '0;
  logic [1:0]        m_wready;
  logic [2*ID_W-1:0] m_bid;
  logic [3:0]        m_bresp;
  logic [1:0]        m_bvalid;
  logic [1:0]        m_bready = '0;
  logic [AW_W-1:0]   s_aw;
  logic              s_awvalid;
  logic              s_awready = 1'b0;
  logic [W_W-1:0]    s_w;
  logic              s_wvalid;
  logic              s_wready = 1'b0;
  logic [ID_W-1:0]   s_bid = '0;
  logic [1:0]        s_bresp = '0;
  logic              s_bvalid = 1'b0;
  logic              s_bready;
  logic [1:0]        grant;
  logic              wlast_err;

  axi_wr_rr_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m_aw(m_aw), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_w(m_w), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_aw(s_aw), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_w(s_w), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations collected by the burst driver, judged by the scenario tasks.
  int         obs_lat, obs_beats, obs_last_idx, obs_last_cnt, obs_data_err;
  int         obs_err, obs_early, obs_leak, obs_timeout;
  logic [1:0] obs_grant, obs_grant_after, obs_bvalid, obs_bresp;
  logic [7:0] obs_bid;
  logic       obs_aw_ok, obs_idle_rdy, obs_sbready;

  function automatic logic [AW_W-1:0] mk_aw(input int req, input int len);
    logic [7:0]  id;
    logic [15:0] addr;
    id   = 8'(8'h10 + req);
    addr = 16'(16'h1000 * (req + 1));
    return {id, addr, len[7:0], 3'd2, 2'b01};
  endfunction

  function automatic logic [W_W-1:0] mk_w(input int req, input int beat, input bit last);
    logic [31:0] d;
    d = 32'(32'hA000_0000 + req * 65536 + beat);
    return {d, 4'hF, last};
  endfunction

  // Runs one burst for whichever requester in mask gets granted; slave answers promptly.
  task automatic burst(input logic [1:0] mask, input int len, input int stall_at,
                       input int stall_len, input int bad_last, input bit early_b);
    int cyc, beat, req, stall_left;
    obs_lat = -1; obs_beats = 0; obs_last_idx = -1; obs_last_cnt = 0; obs_data_err = 0;
    obs_err = 0; obs_early = 0; obs_leak = 0; obs_timeout = 0;
    obs_grant = 2'b00; obs_grant_after = 2'b11; obs_bvalid = 2'b00; obs_bresp = 2'b11;
    obs_bid = 8'hFF; obs_aw_ok = 1'b0; obs_idle_rdy = 1'b0; obs_sbready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (mask[r]) begin
        m_aw[r*AW_W +: AW_W] = mk_aw(r, len);
        m_awvalid[r] = 1'b1;
      end
    end
    s_awready = 1'b1;
    #1;
    obs_idle_rdy = (m_awready != 2'b00) || s_awvalid;
    cyc = 0;
    while (!s_awvalid && cyc < 8) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (!s_awvalid) begin
      obs_timeout = 1;
      return;
    end
    obs_lat   = cyc;
    obs_grant = grant;
    req       = grant[1] ? 1 : 0;
    obs_aw_ok = (s_aw === mk_aw(req, len)) && (m_awready === grant);
    @(posedge clk); #1;
    m_awvalid[req] = 1'b0;
    s_awready      = 1'b0;
    s_bvalid       = early_b;
    s_bid          = 8'h77;
    beat = 0; stall_left = stall_len; cyc = 0;
    while (beat <= len && cyc < len + 40) begin
      m_w[req*W_W +: W_W] = mk_w(req, beat, (beat == len) ^ (beat == bad_last));
      m_wvalid[req] = 1'b1;
      if (beat == stall_at && stall_left > 0) begin
        s_wready = 1'b0;
        stall_left--;
      end else begin
        s_wready = 1'b1;
      end
      #1;
      if (wlast_err) obs_err++;
      if (s_bready || m_bvalid != 2'b00) obs_early++;
      if (((m_awready | m_wready) & ~grant) != 2'b00) obs_leak++;
      if (s_wvalid && s_wready) begin
        if (s_w !== mk_w(req, beat, beat == len)) obs_data_err++;
        if (s_w[0]) begin
          obs_last_idx = beat;
          obs_last_cnt++;
        end
        obs_beats++;
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_wvalid[req] = 1'b0;
    s_wready      = 1'b0;
    if (beat <= len) begin
      obs_timeout = 1;
      s_bvalid = 1'b0;
      return;
    end
    s_bvalid       = 1'b1;
    s_bid          = 8'(8'h10 + req);
    s_bresp        = (req == 1) ? 2'b10 : 2'b00;
    m_bready[req]  = 1'b1;
    #1;
    if (wlast_err) obs_err++;
    obs_sbready = s_bready;
    obs_bvalid  = m_bvalid;
    obs_bid     = m_bid[req*ID_W +: ID_W];
    obs_bresp   = m_bresp[req*2 +: 2];
    @(posedge clk); #1;
    s_bvalid = 1'b0;
    s_bid    = '0;
    s_bresp  = 2'b00;
    m_bready = 2'b00;
    obs_grant_after = grant;
    if (wlast_err) obs_err++;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    m_awvalid = 2'b11;
    s_bvalid  = 1'b1;
    #1;
    n_checks++;
    if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, wlast_err} !== 10'd0)
      $display("FAIL reset_outputs: got %b want 0", {s_awvalid, s_wvalid, s_bready,
               m_awready, m_wready, m_bvalid, wlast_err});
    else n_pass++;
    m_awvalid = 2'b00;
    s_bvalid  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    burst(2'b01, 3, -1, 0, -1, 1'b0);
    n_checks++;
    if (obs_timeout !== 0) $display("FAIL single_timeout: got %0d want 0", obs_timeout);
    else n_pass++;
    n_checks++;
    if (obs_idle_rdy !== 1'b0) $display("FAIL single_idle_ready: got %b want 0", obs_idle_rdy);
    else n_pass++;
    n_checks++;
    if (obs_lat !== 1) $display("FAIL single_aw_latency: got %0d want 1", obs_lat);
    else n_pass++;
    n_checks++;
    if (obs_grant !== 2'b01) $display("FAIL single_grant: got %b want 01", obs_grant);
    else n_pass++;
    n_checks++;
    if (obs_aw_ok !== 1'b1) $display("FAIL single_aw_payload: got %b want 1", obs_aw_ok);
    else n_pass++;
    n_checks++;
    if (obs_beats !== 4 || obs_data_err !== 0)
      $display("FAIL single_beats: got %0d beats %0d bad want 4 beats 0 bad", obs_beats,
               obs_data_err);
    else n_pass++;
    n_checks++;
    if (obs_last_idx !== 3 || obs_last_cnt !== 1)
      $display("FAIL single_wlast: got idx %0d cnt %0d want idx 3 cnt 1", obs_last_idx,
               obs_last_cnt);
    else n_pass++;
    n_checks++;
    if (obs_bvalid !== 2'b01 || obs_bresp !== 2'b00 || obs_bid !== 8'h10)
      $display("FAIL single_bresp: got bvalid %b bresp %b bid %h want 01 00 10", obs_bvalid,
               obs_bresp, obs_bid);
    else n_pass++;
    n_checks++;
    if (obs_grant_after !== 2'b00) $display("FAIL single_grant_after: got %b want 00",
                                            obs_grant_after);
    else n_pass++;
    n_checks++;
    if (obs_err !== 0 || obs_early !== 0)
      $display("FAIL single_spurious: got err %0d early %0d want 0 0", obs_err, obs_early);
    else n_pass++;
  endtask

  task automatic test_fairness;
    logic [1:0] exp_g;
    int leaks;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    leaks = 0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      burst(2'b11, 0, -1, 0, -1, 1'b0);
      leaks += obs_leak;
      n_checks++;
      if (obs_grant !== exp_g || obs_timeout !== 0)
        $display("FAIL fair_order_%0d: got grant %b timeout %0d want %b 0", i, obs_grant,
                 obs_timeout, exp_g);
      else n_pass++;
    end
    m_awvalid = 2'b00;
    n_checks++;
    if (leaks !== 0) $display("FAIL fair_other_ready: got %0d want 0", leaks);
    else n_pass++;
  endtask

  task automatic test_wready_stall;
    burst(2'b01, 7, 3, 3, -1, 1'b0);
    n_checks++;
    if (obs_beats !== 8 || obs_data_err !== 0 || obs_timeout !== 0)
      $display("FAIL stall_beats: got %0d beats %0d bad to %0d want 8 0 0", obs_beats,
               obs_data_err, obs_timeout);
    else n_pass++;
    n_checks++;
    if (obs_last_idx !== 7 || obs_last_cnt !== 1)
      $display("FAIL stall_wlast: got idx %0d cnt %0d want 7 1", obs_last_idx, obs_last_cnt);
    else n_pass++;
  endtask

  task automatic test_wlast_err;
    burst(2'b10, 2, -1, 0, 1, 1'b0);
    n_checks++;
    if (obs_last_idx !== 2 || obs_last_cnt !== 1 || obs_data_err !== 0)
      $display("FAIL werr_wlast: got idx %0d cnt %0d bad %0d want 2 1 0", obs_last_idx,
               obs_last_cnt, obs_data_err);
    else n_pass++;
    n_checks++;
    if (obs_err !== 1) $display("FAIL werr_pulse: got %0d want 1", obs_err);
    else n_pass++;
    n_checks++;
    if (obs_bvalid !== 2'b10 || obs_bresp !== 2'b10 || obs_bid !== 8'h11)
      $display("FAIL werr_bresp: got bvalid %b bresp %b bid %h want 10 10 11", obs_bvalid,
               obs_bresp, obs_bid);
    else n_pass++;
  endtask

  task automatic test_long_burst;
    burst(2'b01, 255, -1, 0, -1, 1'b1);
    n_checks++;
    if (obs_beats !== 256 || obs_data_err !== 0 || obs_timeout !== 0)
      $display("FAIL long_beats: got %0d beats %0d bad to %0d want 256 0 0", obs_beats,
               obs_data_err, obs_timeout);
    else n_pass++;
    n_checks++;
    if (obs_last_idx !== 255 || obs_last_cnt !== 1)
      $display("FAIL long_wlast: got idx %0d cnt %0d want 255 1", obs_last_idx, obs_last_cnt);
    else n_pass++;
    n_checks++;
    if (obs_early !== 0 || obs_sbready !== 1'b1)
      $display("FAIL long_early_b: got early %0d bready %b want 0 1", obs_early, obs_sbready);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    m_aw[AW_W +: AW_W] = mk_aw(1, 15);
    m_w[W_W +: W_W]    = mk_w(1, 0, 1'b0);
    m_awvalid = 2'b10;
    m_wvalid  = 2'b10;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (grant !== 2'b10 || s_wvalid !== 1'b1)
      $display("FAIL rmid_in_w: got grant %b wvalid %b want 10 1", grant, s_wvalid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({grant, s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid} !== 11'd0)
      $display("FAIL rmid_outputs: got %b want 0", {grant, s_awvalid, s_wvalid, s_bready,
               m_awready, m_wready, m_bvalid});
    else n_pass++;
    m_awvalid = 2'b00;
    m_wvalid  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    burst(2'b11, 0, -1, 0, -1, 1'b0);
    m_awvalid = 2'b00;
    n_checks++;
    if (obs_grant !== 2'b01 || obs_timeout !== 0)
      $display("FAIL rmid_next_grant: got %b timeout %0d want 01 0", obs_grant, obs_timeout);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wready_stall();
    test_wlast_err();
    test_long_burst();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
